pipe_alu_p: RTL and testbench

PIPE_ALU_P -- requirements
Module: pipe_alu_p

---
 rtl/pipe_alu_p_pkg.sv | 32 +++
 rtl/pipe_alu_core.sv | 66 ++++++
 rtl/pipe_alu_p.sv | 152 +++++++++++++++
 tb/tb_pipe_alu_p.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_alu_p_pkg.sv
// Shared definitions for the pipelined ALU: operation codes and the
// flag bundle produced alongside every execute-stage result.
package pipe_alu_p_pkg;

  typedef enum logic [3:0] {
    FN_ADD   = 4'd0,
    FN_SUB   = 4'd1,
    FN_MUL   = 4'd2,
    FN_PASSA = 4'd3,
    FN_PASSB = 4'd4,
    FN_AND   = 4'd5,
    FN_OR    = 4'd6,
    FN_XOR   = 4'd7,
    FN_NOTA  = 4'd8,
    FN_NOTB  = 4'd9,
    FN_SRL1  = 4'd10,
    FN_SLL1  = 4'd11,
    FN_SRA1  = 4'd12,
    FN_SLTS  = 4'd13,
    FN_SLTU  = 4'd14,
    FN_RSV   = 4'd15
  } func_e;

  // Flags that travel with a result through the pipeline.
  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic illegal;
  } alu_flags_t;

endpackage

// File: rtl/pipe_alu_core.sv
// Combinational execute unit: operands and operation code in,
// result and flags out. The reserved code yields zero and raises illegal.
module pipe_alu_core
  import pipe_alu_p_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        func,
  output logic [DATA_W-1:0] result,
  output alu_flags_t        flags
);

  logic [DATA_W:0] wide;
  logic            carry;
  logic            bad;

  // Select the operation and derive carry/borrow/shift-out, then the flags.
  always_comb begin
    wide   = '0;
    result = '0;
    carry  = 1'b0;
    bad    = 1'b0;
    case (func_e'(func))
      FN_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
      end
      FN_SUB: begin
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
      end
      FN_MUL:   result = a * b;
      FN_PASSA: result = a;
      FN_PASSB: result = b;
      FN_AND:   result = a & b;
      FN_OR:    result = a | b;
      FN_XOR:   result = a ^ b;
      FN_NOTA:  result = ~a;
      FN_NOTB:  result = ~b;
      FN_SRL1: begin
        result = a >> 1;
        carry  = a[0];
      end
      FN_SLL1: begin
        result = a << 1;
        carry  = a[DATA_W-1];
      end
      FN_SRA1: begin
        result = DATA_W'($signed(a) >>> 1);
        carry  = a[0];
      end
      FN_SLTS: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      FN_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
      default: bad = 1'b1;
    endcase
    flags.z       = (result == '0);
    flags.n       = result[DATA_W-1];
    flags.c       = carry;
    flags.illegal = bad;
  end

endmodule

// File: rtl/pipe_alu_p.sv
// Four-stage ALU pipeline: S1 operand read, S2 execute, S3 register
// writeback and Zout, S4 memory write. Forwarding from S3 into S2 and
// write-through into S1 reads remove every hazard without stalling.
module pipe_alu_p
  import pipe_alu_p_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int NREG   = 16,
  parameter  int MEM_AW = 8,
  localparam int REG_AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  // Handshake: in_valid qualifies rs1/rs2/rd/func/addr for one cycle and the
  // instruction is taken on that rising edge; there is no ready, nothing stalls.
  // out_valid marks the single cycle in which Zout and the flags describe a
  // newly completed instruction; otherwise they hold their last values.
  input  logic              in_valid,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rd,
  input  logic [3:0]        func,
  input  logic [MEM_AW-1:0] addr,
  input  logic              ld_en,
  input  logic [REG_AW-1:0] ld_idx,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [MEM_AW-1:0] mem_raddr,
  output logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] Zout,
  output logic              out_valid,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic              illegal
);

  logic [DATA_W-1:0] regbank [NREG];
  logic [DATA_W-1:0] mem [2**MEM_AW];

  // Operands captured by S1, consumed by S2.
  logic              s2_valid;
  logic [REG_AW-1:0] s2_rs1, s2_rs2, s2_rd;
  logic [3:0]        s2_func;
  logic [MEM_AW-1:0] s2_addr;
  logic [DATA_W-1:0] s2_a, s2_b;
  // Execute results waiting for writeback.
  logic              s3_valid;
  logic [REG_AW-1:0] s3_rd;
  logic [MEM_AW-1:0] s3_addr;
  logic [DATA_W-1:0] s3_result;
  alu_flags_t        s3_flags;
  // Memory write stage.
  logic              s4_valid;
  logic [MEM_AW-1:0] s4_addr;
  logic [DATA_W-1:0] s4_data;

  logic              wb_en;
  logic [DATA_W-1:0] rd_a, rd_b, ex_a, ex_b, ex_result;
  alu_flags_t        ex_flags, out_flags;

  // Only legal, valid S3 instructions write back or forward.
  assign wb_en = s3_valid && !s3_flags.illegal;

  // S1 reads see a writeback landing on the same edge.
  assign rd_a = (wb_en && s3_rd == rs1) ? s3_result : regbank[rs1];
  assign rd_b = (wb_en && s3_rd == rs2) ? s3_result : regbank[rs2];

  // S2 operands take the not-yet-written S3 result when indices match.
  assign ex_a = (wb_en && s3_rd == s2_rs1) ? s3_result : s2_a;
  assign ex_b = (wb_en && s3_rd == s2_rs2) ? s3_result : s2_b;

  pipe_alu_core #(.DATA_W(DATA_W)) u_core (
    .a      (ex_a),
    .b      (ex_b),
    .func   (s2_func),
    .result (ex_result),
    .flags  (ex_flags)
  );

  // Advance the pipeline; reset drops every in-flight instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_rs1    <= '0;
      s2_rs2    <= '0;
      s2_rd     <= '0;
      s2_func   <= '0;
      s2_addr   <= '0;
      s2_a      <= '0;
      s2_b      <= '0;
      s3_valid  <= 1'b0;
      s3_rd     <= '0;
      s3_addr   <= '0;
      s3_result <= '0;
      s3_flags  <= '0;
      s4_valid  <= 1'b0;
      s4_addr   <= '0;
      s4_data   <= '0;
    end else begin
      s2_valid  <= in_valid;
      s2_rs1    <= rs1;
      s2_rs2    <= rs2;
      s2_rd     <= rd;
      s2_func   <= func;
      s2_addr   <= addr;
      s2_a      <= rd_a;
      s2_b      <= rd_b;
      s3_valid  <= s2_valid;
      s3_rd     <= s2_rd;
      s3_addr   <= s2_addr;
      s3_result <= ex_result;
      s3_flags  <= ex_flags;
      s4_valid  <= wb_en;
      s4_addr   <= s3_addr;
      s4_data   <= s3_result;
    end
  end

  // Present the S3 result; bubbles leave Zout and flags untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Zout      <= '0;
      out_flags <= '0;
    end else begin
      out_valid <= s3_valid;
      if (s3_valid) begin
        Zout      <= s3_result;
        out_flags <= s3_flags;
      end
    end
  end

  assign flag_z  = out_flags.z;
  assign flag_n  = out_flags.n;
  assign flag_c  = out_flags.c;
  assign illegal = out_flags.illegal;

  // Register bank: direct load first so a same-index writeback overrides it.
  always_ff @(posedge clk) begin
    if (ld_en) regbank[ld_idx] <= ld_data;
    if (wb_en) regbank[s3_rd] <= s3_result;
  end

  // Result memory, written from S4; reads are combinational and see old data.
  always_ff @(posedge clk) begin
    if (s4_valid) mem[s4_addr] <= s4_data;
  end

  assign mem_rdata = mem[mem_raddr];

endmodule

// File: tb/tb_pipe_alu_p.sv
// Directed bench for pipe_alu_p: a vector table for every operation, then
// hand-written sequences for forwarding, write-through, load/writeback
// collisions, the reserved code and reset with work in flight.
module tb_pipe_alu_p;
  import pipe_alu_p_pkg::*;

  localparam int DATA_W = 16;
  localparam int NREG   = 16;
  localparam int MEM_AW = 8;
  localparam int REG_AW = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [REG_AW-1:0] rs1 = '0, rs2 = '0, rd = '0, ld_idx = '0;
  logic [3:0]        func = '0;
  logic [MEM_AW-1:0] addr = '0, mem_raddr = '0;
  logic              ld_en = 1'b0;
  logic [DATA_W-1:0] ld_data = '0;
  logic [DATA_W-1:0] mem_rdata, Zout;
  logic              out_valid, flag_z, flag_n, flag_c, illegal;

  typedef struct {
    logic [3:0]        f;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] res;
    logic [3:0]        fl;  // {z, n, c, illegal}
  } vec_t;

  vec_t              vq[$];
  logic [DATA_W-1:0] exp_q[$];
  int                checks = 0;
  int                errors = 0;

  pipe_alu_p #(.DATA_W(DATA_W), .NREG(NREG), .MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .rs1(rs1), .rs2(rs2),
    .rd(rd), .func(func), .addr(addr), .ld_en(ld_en), .ld_idx(ld_idx),
    .ld_data(ld_data), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .Zout(Zout), .out_valid(out_valid), .flag_z(flag_z), .flag_n(flag_n),
    .flag_c(flag_c), .illegal(illegal)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Driver and scoreboard tasks
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] res, input logic [3:0] fl);
    vec_t v;
    v.f = f; v.a = a; v.b = b; v.res = res; v.fl = fl;
    vq.push_back(v);
  endtask

  task automatic load(input int idx, input logic [DATA_W-1:0] d);
    ld_en = 1'b1; ld_idx = idx[REG_AW-1:0]; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic issue(input logic [3:0] f, input int r1, input int r2, input int d, input int a);
    in_valid = 1'b1; func = f;
    rs1 = r1[REG_AW-1:0]; rs2 = r2[REG_AW-1:0]; rd = d[REG_AW-1:0]; addr = a[MEM_AW-1:0];
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_reg(input string name, input int idx, input logic [DATA_W-1:0] exp);
    issue(FN_PASSA, idx, 0, 15, 255);
    repeat (2) @(negedge clk);
    chk(name, Zout, exp);
  endtask

  task automatic check_mem(input string name, input int a, input logic [DATA_W-1:0] exp);
    mem_raddr = a[MEM_AW-1:0];
    #1;
    chk(name, mem_rdata, exp);
  endtask

  // Stimulus
  initial begin
    add_vec(FN_ADD,   16'h0005, 16'h0003, 16'h0008, 4'b0000);
    add_vec(FN_ADD,   16'hFFFF, 16'h0001, 16'h0000, 4'b1010);
    add_vec(FN_SUB,   16'h0003, 16'h0005, 16'hFFFE, 4'b0110);
    add_vec(FN_SUB,   16'h0005, 16'h0005, 16'h0000, 4'b1000);
    add_vec(FN_MUL,   16'h012C, 16'h012C, 16'h5F90, 4'b0000);
    add_vec(FN_PASSA, 16'h1234, 16'h0000, 16'h1234, 4'b0000);
    add_vec(FN_PASSB, 16'h1234, 16'h8001, 16'h8001, 4'b0100);
    add_vec(FN_AND,   16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000);
    add_vec(FN_OR,    16'hF0F0, 16'h3C3C, 16'hFCFC, 4'b0100);
    add_vec(FN_XOR,   16'hF0F0, 16'h3C3C, 16'hCCCC, 4'b0100);
    add_vec(FN_NOTA,  16'h00FF, 16'h0000, 16'hFF00, 4'b0100);
    add_vec(FN_NOTB,  16'h0000, 16'hFFFF, 16'h0000, 4'b1000);
    add_vec(FN_SRL1,  16'h8000, 16'h0000, 16'h4000, 4'b0000);
    add_vec(FN_SRL1,  16'h0003, 16'h0000, 16'h0001, 4'b0010);
    add_vec(FN_SLL1,  16'h8000, 16'h0000, 16'h0000, 4'b1010);
    add_vec(FN_SLL1,  16'h4001, 16'h0000, 16'h8002, 4'b0100);
    add_vec(FN_SRA1,  16'h8000, 16'h0000, 16'hC000, 4'b0100);
    add_vec(FN_SRA1,  16'h0003, 16'h0000, 16'h0001, 4'b0010);
    add_vec(FN_SLTS,  16'hFFFF, 16'h0001, 16'h0001, 4'b0000);
    add_vec(FN_SLTU,  16'hFFFF, 16'h0001, 16'h0000, 4'b1000);
    add_vec(FN_SLTS,  16'h0001, 16'hFFFF, 16'h0000, 4'b1000);
    add_vec(FN_SLTU,  16'h0001, 16'hFFFF, 16'h0001, 4'b0000);
    add_vec(FN_RSV,   16'h1234, 16'h5678, 16'h0000, 4'b1001);

    // Reset state
    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_zout", Zout, 0);
    chk("reset_flags", {flag_z, flag_n, flag_c, illegal}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table: every operation with its flags and memory result
    for (int i = 0; i < vq.size(); i++) begin
      load(1, vq[i].a);
      load(2, vq[i].b);
      issue(vq[i].f, 1, 2, 6, i);
      repeat (2) @(negedge clk);
      chk($sformatf("vec%0d_zout", i), Zout, vq[i].res);
      chk($sformatf("vec%0d_flags", i), {flag_z, flag_n, flag_c, illegal}, vq[i].fl);
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      mem_raddr = i[MEM_AW-1:0];
      @(negedge clk);
      if (!vq[i].fl[0]) chk($sformatf("vec%0d_mem", i), mem_rdata, vq[i].res);
    end

    // Back-to-back forwarding, including rs1==rs2
    load(1, 16'h0005);
    load(2, 16'h0003);
    exp_q.push_back(16'h0008);
    exp_q.push_back(16'h0003);
    exp_q.push_back(16'h0010);
    issue(FN_ADD, 1, 2, 3, 16'h10);
    issue(FN_SUB, 3, 1, 4, 16'h11);
    issue(FN_ADD, 3, 3, 5, 16'h12);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("fwd%0d_zout", j), Zout, exp_q.pop_front());
      chk($sformatf("fwd%0d_valid", j), out_valid, 1);
      @(negedge clk);
    end
    check_mem("fwd_mem0", 16'h10, 16'h0008);
    check_mem("fwd_mem1", 16'h11, 16'h0003);

    // One-cycle gap: write-through into S1 and bubble holding Zout
    load(3, 16'h1234);
    issue(FN_ADD, 1, 2, 3, 16'h13);
    @(negedge clk);
    issue(FN_XOR, 3, 3, 4, 16'h14);
    chk("gap_add_zout", Zout, 16'h0008);
    @(negedge clk);
    chk("gap_bubble_valid", out_valid, 0);
    chk("gap_bubble_hold", Zout, 16'h0008);
    @(negedge clk);
    chk("gap_xor_zout", Zout, 16'h0000);
    chk("gap_xor_z", flag_z, 1);
    load(3, 16'h1234);
    issue(FN_ADD, 1, 2, 3, 16'h15);
    @(negedge clk);
    issue(FN_SUB, 3, 1, 7, 16'h16);
    repeat (2) @(negedge clk);
    chk("wthru_sub_zout", Zout, 16'h0003);

    // Same-edge load and writeback: same index keeps writeback, else both land
    issue(FN_PASSA, 1, 0, 5, 16'h17);
    @(negedge clk);
    load(5, 16'h9999);
    check_reg("collide_same_r5", 5, 16'h0005);
    issue(FN_PASSA, 2, 0, 8, 16'h18);
    @(negedge clk);
    load(9, 16'hABCD);
    check_reg("collide_diff_r8", 8, 16'h0003);
    check_reg("collide_diff_r9", 9, 16'hABCD);

    // Reserved code: no write, no forwarding
    issue(FN_PASSA, 2, 0, 7, 16'h40);
    repeat (3) @(negedge clk);
    issue(FN_RSV, 2, 2, 1, 16'h40);
    issue(FN_PASSA, 1, 0, 7, 16'h41);
    @(negedge clk);
    chk("rsv_illegal", illegal, 1);
    chk("rsv_zout", Zout, 16'h0000);
    chk("rsv_valid", out_valid, 1);
    @(negedge clk);
    chk("rsv_nofwd_zout", Zout, 16'h0005);
    chk("rsv_nofwd_illegal", illegal, 0);
    check_mem("rsv_mem", 16'h40, 16'h0003);
    check_reg("rsv_r1", 1, 16'h0005);

    // Reset with instructions in flight
    load(11, 16'h1111);
    issue(FN_PASSA, 11, 0, 12, 16'h50);
    issue(FN_PASSA, 11, 0, 12, 16'h51);
    issue(FN_PASSA, 11, 0, 12, 16'h52);
    repeat (3) @(negedge clk);
    issue(FN_RSV, 1, 2, 12, 16'h50);
    issue(FN_ADD, 1, 2, 12, 16'h51);
    issue(FN_ADD, 1, 2, 12, 16'h52);
    chk("rst_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_flags", {flag_z, flag_n, flag_c, illegal}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_mem("rst_mem51", 16'h51, 16'h1111);
    check_mem("rst_mem52", 16'h52, 16'h1111);
    check_reg("rst_r12", 12, 16'h1111);
    issue(FN_ADD, 1, 2, 12, 16'h50);
    repeat (2) @(negedge clk);
    chk("post_rst_zout", Zout, 16'h0008);
    chk("post_rst_valid", out_valid, 1);
    check_mem("post_rst_mem_old", 16'h50, 16'h1111);
    @(negedge clk);
    check_mem("post_rst_mem_new", 16'h50, 16'h0008);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
